// File: rtl/car_cruise_sched_if.sv
// Target-speed request handshake between the cruise requester and car_cruise_sched.
// The requester owns valid/speed; the sequencer answers with ready.
interface car_cruise_sched_if;
  logic       set_valid;
  logic [1:0] set_speed;
  logic       set_ready;

  modport master (output set_valid, output set_speed, input set_ready);
  modport slave  (input set_valid, input set_speed, output set_ready);
endinterface

// File: rtl/car_cruise_sched.sv
// Cruise sequencer: steps the 2-bit speed one level per dwell period toward a
// latched target, holds it, passes driver pedals through when disengaged.
module car_cruise_sched #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 keys,
  car_cruise_sched_if.slave    req,
  input  logic                 driver_brake,
  input  logic                 driver_accel,
  input  logic [1:0]           speed,
  output logic                 brake,
  output logic                 accelerate,
  output logic                 engaged,
  output logic                 done,
  output logic                 fault,
  output logic [1:0]           target
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    ACC  = 3'd2,
    BRK  = 3'd3,
    WAIT = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [1:0]      target_r;
  logic [1:0]      prev_r;
  logic [CW-1:0]   cnt_r;
  logic            ready_s;
  logic            accept_s;
  logic            brake_s;
  logic            accel_s;
  logic            done_s;
  logic            fault_s;
  logic            cancel_s;

  // Ignition loss or the brake pedal cancels the cruise from any engaged state.
  assign cancel_s = (state_r != IDLE) && (!keys || driver_brake);
  assign accept_s = req.set_valid & ready_s;

  // Next-state and step/handshake outputs.
  always_comb begin
    next_state_s = state_r;
    brake_s      = 1'b0;
    accel_s      = 1'b0;
    ready_s      = 1'b0;
    done_s       = 1'b0;
    fault_s      = 1'b0;
    if (cancel_s) begin
      // A pressed brake pedal wins over a pending ACC pulse.
      next_state_s = IDLE;
      brake_s      = driver_brake | (state_r == BRK);
      accel_s      = ~driver_brake & (state_r == ACC);
    end else begin
      case (state_r)
        IDLE: begin
          brake_s = driver_brake;
          accel_s = driver_accel;
          ready_s = keys & ~driver_brake & ~driver_accel;
          if (req.set_valid && ready_s) begin
            next_state_s = CMP;
          end else begin
            next_state_s = IDLE;
          end
        end
        CMP: begin
          if (speed == target_r) begin
            done_s       = 1'b1;
            next_state_s = HOLD;
          end else if (speed < target_r) begin
            next_state_s = ACC;
          end else begin
            next_state_s = BRK;
          end
        end
        ACC: begin
          accel_s      = 1'b1;
          next_state_s = WAIT;
        end
        BRK: begin
          brake_s      = 1'b1;
          next_state_s = WAIT;
        end
        WAIT: begin
          if (cnt_r != {CW{1'b0}}) begin
            next_state_s = WAIT;
          end else if (speed == prev_r) begin
            fault_s      = 1'b1;
            next_state_s = IDLE;
          end else begin
            next_state_s = CMP;
          end
        end
        HOLD: begin
          ready_s = 1'b1;
          if (req.set_valid || (speed != target_r)) begin
            next_state_s = CMP;
          end else begin
            next_state_s = HOLD;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Target latch, pre-step speed snapshot and dwell counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_r <= 2'b00;
      prev_r   <= 2'b00;
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        target_r <= req.set_speed;
      end
      if ((state_r == ACC) || (state_r == BRK)) begin
        prev_r <= speed;
        cnt_r  <= CW'(DWELL - 1);
      end else if ((state_r == WAIT) && (cnt_r != {CW{1'b0}})) begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  assign req.set_ready = ready_s;
  assign brake         = brake_s;
  assign accelerate    = accel_s;
  assign done          = done_s;
  assign fault         = fault_s;
  assign engaged       = (state_r != IDLE);
  assign target        = target_r;

endmodule

// File: doc/car_cruise_sched.md
# car_cruise_sched

Cruise sequencer that sits in front of the car speed controller and drives its `brake`/`accelerate` inputs. It walks the 2-bit speed one level per step toward a requested target speed, paced by a programmable dwell time, and holds that speed until the driver cancels. While the cruise is disengaged, the driver's pedals pass straight through. It also flags a fault if a commanded step produces no speed change.

## Interface
- `DWELL`, default 4: number of cycles waited after each step pulse before the speed is re-evaluated; must be at least 1.
- `CW`, default 8: width of the dwell counter; requires `DWELL` ≤ 2^CW.

Ports (all signals synchronous to `clock` unless noted):
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `keys` in 1: ignition; low forces disengage.
- `set_valid` in 1: target-speed request.
- `set_speed` in 2: requested target (00 STOP, 01 SLOW, 10 MEDIUM, 11 FAST).
- `set_ready` out 1: request accepted on the cycle where `set_valid & set_ready`.
- `driver_brake` in 1: brake pedal.
- `driver_accel` in 1: accelerator pedal.
- `speed` in 2: current speed fed back from the speed controller.
- `brake` out 1: to the speed controller.
- `accelerate` out 1: to the speed controller.
- `engaged` out 1: cruise active; high in every state except IDLE.
- `done` out 1: one-cycle pulse when the target is first reached.
- `fault` out 1: one-cycle pulse when a step is stuck.
- `target` out 2: latched target speed.

## Operation
States: IDLE, CMP, ACC, BRK, WAIT, HOLD.

- **IDLE**
  - `brake = driver_brake`, `accelerate = driver_accel` (combinational pass-through).
  - `set_ready = keys & ~driver_brake & ~driver_accel`.
  - On accept: latch `target <= set_speed`, go to CMP.
- **CMP**
  - `speed == target` → HOLD, with `done` high in this CMP cycle.
  - `speed < target` → ACC.
  - `speed > target` → BRK.
- **ACC** (exactly 1 cycle): `accelerate = 1`; snapshot `prev <= speed`; load the dwell counter with `DWELL-1`; go to WAIT.
- **BRK** (exactly 1 cycle): `brake = 1`; otherwise identical to ACC.
- **WAIT**: both outputs 0; the counter decrements each cycle. When the counter is 0:
  - `speed == prev` → `fault` pulse in this cycle, go to IDLE.
  - Otherwise → CMP.
- **HOLD**
  - Both outputs 0; `set_ready = 1`.
  - An accepted new request re-latches `target` and goes to CMP.
  - If `speed != target` (drift), go to CMP with no new request.

Override rules, applied in every state except IDLE:
- `~keys` → IDLE next cycle. This has priority over everything.
- `driver_brake` → IDLE next cycle. During that cycle `brake = 1`, `accelerate = 0`, and `driver_brake` overrides any ACC pulse.
- `driver_accel` is ignored while engaged.

Other rules:
- `set_ready` is 0 in CMP, ACC, BRK and WAIT; `set_valid` in those states is not accepted and is not queued.
- `done` and `fault` never assert in the same cycle.
- `target` is unchanged on cancel.
- Comparisons are unsigned 2-bit.

## Timing
- Reset values: state IDLE, `target = 00`, counter 0, `prev = 00`, `engaged = 0`, `done = 0`, `fault = 0`.
- During reset, `brake`/`accelerate` follow the driver pedals and `set_ready = keys & ~pedals`.
- Reset asserted mid-step returns to IDLE immediately and aborts any step pulse.
- Timeline for a step:
  - Accept at edge E0; CMP during cycle 1.
  - ACC/BRK during cycle 2.
  - WAIT during cycles 3 … 2+DWELL.
  - Next CMP at cycle 3+DWELL.
- Per-step period is DWELL+2 cycles. A target n levels away asserts `done` in cycle 1 + n·(DWELL+2).
- Target equal to the current speed gives `done` in cycle 1, with no step pulses.
- The speed controller samples the step pulse at the edge ending ACC/BRK, so the new speed is visible from the first WAIT cycle.

## Test plan
- **Accelerate from STOP:** `DWELL=4`, speed STOP, `set_speed=11` accepted. Expect 3 one-cycle `accelerate` pulses 6 cycles apart; speed becomes 11; `done` in cycle 19; state HOLD, `engaged = 1`.
- **Decelerate, then drift:** from HOLD at FAST, request `01`. Expect 2 `brake` pulses; `done` at cycle 13. Then force `speed` to 00 externally: CMP → ACC, one `accelerate` pulse, `done` again.
- **Driver override:** `driver_brake` high while in WAIT. Expect `brake = 1` that cycle, IDLE next, `engaged = 0`, no `done`. `driver_accel` held high while engaged must cause no effect.
- **Stuck step:** speed input tied to 01, target 11. Expect one `accelerate` pulse, then `fault` in the last WAIT cycle, then IDLE; no `done`.
- **Handshake gating:** `set_valid` held with `driver_accel = 1` in IDLE → not accepted. `set_valid` in WAIT → not accepted. `set_valid` with `keys = 0` → not accepted. Same-target request → `done` in cycle 1.
- **Resets:** async `reset` pulse mid-ACC → `accelerate` drops immediately, all registers return to their reset values. `keys` dropping in HOLD → IDLE next cycle.
